// File: rtl/snow64_bfloat16_add_sub_lanes.sv
// snow64_bfloat16_add_sub_lanes: NUM_LANES-wide BFloat16 add/sub on a 4-state FSM (idle, align, sum, norm).
// Define SNOW64_BFLOAT16_ADD_SUB_ROUND_NEAREST_EN to round to nearest even; by default the buffer bits are truncated.
module snow64_bfloat16_add_sub_lanes #(
    parameter int NUM_LANES   = 4,
    parameter int BUFFER_BITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_start,
    input  logic                      in_sub,
    input  logic [16*NUM_LANES-1:0]   in_a,
    input  logic [16*NUM_LANES-1:0]   in_b,
    output logic [16*NUM_LANES-1:0]   out_data,
    output logic                      out_data_valid,
    output logic                      out_can_accept_cmd
);
    localparam int HB = 7 + BUFFER_BITS;
    typedef enum logic [1:0] {StIdle, StAlign, StSum, StNorm} state_t;
    state_t                  state_q, state_d;
    logic [16*NUM_LANES-1:0] a_q, a_d, b_q, b_d, out_data_q, out_data_d, res;
    logic                    sub_q, sub_d, valid_q, valid_d, accept;

    assign accept             = state_q == StIdle && in_start;
    assign out_data           = out_data_q;
    assign out_data_valid     = valid_q;
    assign out_can_accept_cmd = state_q == StIdle;

    // FSM sequencing, command capture and result register
    always_comb begin
        state_d    = state_q == StIdle ? (in_start ? StAlign : StIdle)
                   : state_q == StAlign ? StSum : state_q == StSum ? StNorm : StIdle;
        a_d        = accept ? in_a : a_q;
        b_d        = accept ? in_b : b_q;
        sub_d      = accept ? in_sub : sub_q;
        out_data_d = state_q == StNorm ? res : out_data_q;
        valid_d    = state_q == StNorm ? 1'b1 : accept ? 1'b0 : valid_q;
    end

    // state, command and result registers; reset aborts any command in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            out_data_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sub_q      <= sub_d;
            out_data_q <= out_data_d;
            valid_q    <= valid_d;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [8:0]  d_q, d_d, exp_q, exp_d;
        logic [15:0] sig_a_q, sig_a_d, sig_b_q, sig_b_d, sum_q, sum_d;
        logic        sign_q, sign_d;
        logic [7:0]  ia, ib, ea, eb, rm;
        logic [15:0] fa, fb, sm, sh, al, nm;
        logic [16:0] df;
        logic [3:0]  msb, sft;
        logic [9:0]  ne, re;
        logic        a_big, sa, sb, carry, uflow, up, unused_bits;

        assign ia    = in_a[16*i+14 -: 8];
        assign ib    = in_b[16*i+14 -: 8];
        assign ea    = a_q[16*i+14 -: 8];
        assign eb    = b_q[16*i+14 -: 8];
        // a zero exponent means the operand is zero whatever its mantissa holds
        assign fa    = ea == 8'd0 ? 16'd0 : 16'({1'b1, a_q[16*i+6 -: 7]}) << BUFFER_BITS;
        assign fb    = eb == 8'd0 ? 16'd0 : 16'({1'b1, b_q[16*i+6 -: 7]}) << BUFFER_BITS;
        assign a_big = ea >= eb;
        assign sm    = a_big ? fb : fa;
        assign sh    = sm >> d_q[3:0];
        assign al    = d_q >= 9'd16 ? {15'd0, |sm} : sh | {15'd0, (sh << d_q[3:0]) != sm};
        assign sa    = a_q[16*i+15];
        assign sb    = b_q[16*i+15] ^ sub_q;
        assign df    = {1'b0, sig_a_q} - {1'b0, sig_b_q};

        // per-lane stage work, selected by the shared FSM state
        always_comb begin
            d_d     = accept ? (ia >= ib ? {1'b0, ia - ib} : {1'b0, ib - ia}) : d_q;
            exp_d   = accept ? {1'b0, (ia >= ib ? ia : ib)} : exp_q;
            sig_a_d = state_q == StAlign ? (a_big ? fa : al) : sig_a_q;
            sig_b_d = state_q == StAlign ? (a_big ? al : fb) : sig_b_q;
            sum_d   = state_q != StSum ? sum_q
                    : sa == sb ? sig_a_q + sig_b_q : df[16] ? 16'(-df) : df[15:0];
            sign_d  = state_q != StSum ? sign_q : (sa == sb || !df[16]) ? sa : sb;
        end

        // position of the leading one at or below the hidden-bit slot
        always_comb begin
            msb = 4'd0;
            for (int k = 0; k <= HB; k++) msb = sum_q[k] ? 4'(k) : msb;
        end

        assign carry = sum_q[HB+1];
        assign sft   = 4'(HB) - msb;
        assign nm    = carry ? (sum_q >> 1) | {15'd0, sum_q[0]} : sum_q << sft;
        assign ne    = carry ? {1'b0, exp_q} + 10'd1 : {1'b0, exp_q} - {6'd0, sft};
        assign uflow = !carry && {1'b0, exp_q} <= {6'd0, sft};
`ifdef SNOW64_BFLOAT16_ADD_SUB_ROUND_NEAREST_EN
        assign up    = nm[BUFFER_BITS-1] & (nm[BUFFER_BITS-2] | (|nm[BUFFER_BITS-3:0]) | nm[BUFFER_BITS]);
`else
        assign up    = 1'b0;
`endif
        // rm[7] is the mantissa overflow from rounding, folded into the exponent
        assign rm    = {1'b0, nm[HB-1:BUFFER_BITS]} + {7'd0, up};
        assign re    = ne + {9'd0, rm[7]};
        assign res[16*i+15 -: 16] = (sum_q == 16'd0 || uflow) ? 16'd0
                                  : re >= 10'h0FF ? {sign_q, 8'hFE, 7'h7F} : {sign_q, re[7:0], rm[6:0]};
        assign unused_bits = ^{nm[15:HB], nm[BUFFER_BITS-1:0]};

        // lane pipeline registers
        always_ff @(posedge clk) begin
            if (rst) begin
                d_q     <= '0;
                exp_q   <= '0;
                sig_a_q <= '0;
                sig_b_q <= '0;
                sum_q   <= '0;
                sign_q  <= 1'b0;
            end else begin
                d_q     <= d_d;
                exp_q   <= exp_d;
                sig_a_q <= sig_a_d;
                sig_b_q <= sig_b_d;
                sum_q   <= sum_d;
                sign_q  <= sign_d;
            end
        end
    end
endmodule

// File: tb/tb_snow64_bfloat16_add_sub_lanes.sv
// tb_snow64_bfloat16_add_sub_lanes: directed vectors, queue scoreboard drained by a separate result monitor.
module tb_snow64_bfloat16_add_sub_lanes;
    logic        clk = 1'b0, rst = 1'b1, in_start = 1'b1, in_sub = 1'b0;
    logic [63:0] in_a = '0, in_b = '0, out_data;
    logic        out_data_valid, out_can_accept_cmd;
    int          checks = 0, failures = 0, cyc = 0, busy, acc;
    logic        can, prev_v = 1'b0;
    logic [63:0] sb_q[$];
    int          acc_q[$];

    localparam logic [63:0] A1 = 64'h7F7F_3F80_4040_3F80, B1 = 64'h7F7F_BF80_BF80_4000, E1 = 64'h7F7F_0000_4000_4040;
    localparam logic [63:0] A2 = 64'h3B80_0012_4780_3F81, B2 = 64'h3F81_3F80_3F80_3B80;
    localparam logic [63:0] A3 = 64'h3F80_4040_4040_C040, B3 = 64'h4040_3F80_4040_3F80, E3 = 64'hC000_4000_0000_C080;
    localparam logic [63:0] A4 = 64'h4000_FF7F_3F80_0100, B4 = 64'hBF80_FF7F_0000_80FF, E4 = 64'h3F80_FF7F_3F80_0000;
    localparam logic [63:0] A5 = 64'hBF80_0000_3F80_4780, B5 = 64'hBF80_0000_3F80_BF80;
`ifdef SNOW64_BFLOAT16_ADD_SUB_ROUND_NEAREST_EN
    localparam logic [63:0] E2 = 64'h3F82_3F80_4780_3F82, E5 = 64'hC000_0000_4000_4780;
`else
    localparam logic [63:0] E2 = 64'h3F81_3F80_4780_3F81, E5 = 64'hC000_0000_4000_477F;
`endif

    snow64_bfloat16_add_sub_lanes #(.NUM_LANES(4), .BUFFER_BITS(3)) dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_sub(in_sub), .in_a(in_a), .in_b(in_b),
        .out_data(out_data), .out_data_valid(out_data_valid), .out_can_accept_cmd(out_can_accept_cmd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every rising valid pops one expected result and its accept edge
    always @(negedge clk) begin
        if (out_data_valid === 1'b1 && !prev_v) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got %h expected no result", out_data);
            end else begin
                check("result", out_data, sb_q.pop_front());
                check("latency", 64'(cyc - acc_q.pop_front()), 64'd3);
            end
        end
        prev_v = out_data_valid === 1'b1;
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic [63:0] e, input bit push);
        int n = 0;
        @(negedge clk);
        while (out_can_accept_cmd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (out_can_accept_cmd !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got busy expected idle");
        end else begin
            in_a = a; in_b = b; in_sub = s; in_start = 1'b1;
            @(posedge clk);
            #1;
            if (push) begin
                sb_q.push_back(e);
                acc_q.push_back(cyc);
            end
            in_start = 1'b0; in_a = ~a; in_b = ~b; in_sub = ~s;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb_q.size() != 0; n++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_data", out_data, 64'd0);
        check("reset_valid", {63'd0, out_data_valid}, 64'd0);
        check("reset_can_accept", {63'd0, out_can_accept_cmd}, 64'd1);
        rst = 1'b0;
        in_start = 1'b0;
        issue(A1, B1, 1'b0, E1, 1'b1);
        issue(A2, B2, 1'b0, E2, 1'b1);
        issue(A3, B3, 1'b1, E3, 1'b1);
        issue(A4, B4, 1'b0, E4, 1'b1);
        issue(A5, B5, 1'b0, E5, 1'b1);
        drain();
        in_a = A1; in_b = B1; in_sub = 1'b0;
        @(negedge clk);
        in_start = 1'b1;
        busy = 0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            check("busy_can_accept", {63'd0, out_can_accept_cmd}, {63'd0, busy == 0});
            can = out_can_accept_cmd;
            @(posedge clk);
            #1;
            if (can) begin
                acc++;
                sb_q.push_back(E1);
                acc_q.push_back(cyc);
            end
            busy = busy == 0 ? 3 : busy - 1;
            @(negedge clk);
        end
        in_start = 1'b0;
        check("busy_accepts", 64'(acc), 64'd3);
        drain();
        issue(A3, B3, 1'b1, E3, 1'b1);
        drain();
        issue(A1, B1, 1'b0, E1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_data", out_data, 64'd0);
        check("abort_valid", {63'd0, out_data_valid}, 64'd0);
        check("abort_can_accept", {63'd0, out_can_accept_cmd}, 64'd1);
        repeat (6) @(negedge clk);
        check("abort_no_valid", {63'd0, out_data_valid}, 64'd0);
        issue(A2, B2, 1'b0, E2, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        check("hold_data", out_data, E2);
        check("hold_valid", {63'd0, out_data_valid}, 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
